// File: rtl/control_sequencer.sv
// Micro-sequencer: accepts instructions from fetch, walks the per-class decoder
// steps and drives the datapath control word and constant; traps on bad opcodes.
module control_sequencer #(
    parameter int unsigned        CW_BITS       = 31,
    parameter int unsigned        K_BITS        = 64,
    parameter int unsigned        STATE_BITS    = 2,
    parameter int unsigned        MAX_CYCLES    = 8,
    parameter logic [CW_BITS-1:0] NOP_CW        = '0,
    parameter int unsigned        FLAG_LOAD_BIT = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [4:0]            status,
    input  logic                  stall,
    input  logic                  trap_clear,
    output logic [CW_BITS-1:0]    controlWord,
    output logic [K_BITS-1:0]     K,
    output logic [4:0]            flags,
    output logic [STATE_BITS-1:0] step,
    output logic                  done,
    output logic                  illegal
);

    localparam int unsigned CNT_BITS = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_BITS:0] CNT_LIMIT = (CNT_BITS + 1)'(MAX_CYCLES);

    // Base control word: [0] flag load, [1] reg write, [2] mem read, [3] mem write,
    // [4] ALU src K, [5] PC load, [6] link, [7] cond, [8] cbz, [9] PC from reg,
    // [13:10] ALU op, [15:14] transfer variant, [19:16] class, [24:20] Rd/Rt.
    localparam logic [24:0] FL = 25'h0001;
    localparam logic [24:0] RW = 25'h0002;
    localparam logic [24:0] MR = 25'h0004;
    localparam logic [24:0] MW = 25'h0008;
    localparam logic [24:0] AK = 25'h0010;
    localparam logic [24:0] PC = 25'h0020;
    localparam logic [24:0] LK = 25'h0040;
    localparam logic [24:0] CD = 25'h0080;
    localparam logic [24:0] CZ = 25'h0100;
    localparam logic [24:0] PR = 25'h0200;

    typedef enum logic [1:0] {IDLE, EXEC, TRAP} state_t;

    state_t                state;
    logic [31:0]           ir;
    logic [CNT_BITS-1:0]   cyc;
    logic [CNT_BITS:0]     cyc_next;
    logic [24:0]           dec_cw;
    logic [63:0]           dec_k;
    logic                  dec_ns;
    logic                  dec_illegal;
    logic [STATE_BITS-1:0] next_step;
    logic                  exec_live;
    logic [24:0]           rd_f;

    function automatic logic [24:0] cls(input logic [3:0] c);
        return {5'b0, c, 16'b0};
    endfunction

    function automatic logic [24:0] aop(input logic [3:0] op);
        return {11'b0, op, 10'b0};
    endfunction

    always_comb begin
        dec_cw      = '0;
        dec_k       = '0;
        dec_ns      = 1'b0;
        dec_illegal = 1'b0;
        rd_f        = {ir[4:0], 20'b0};
        if (ir[26]) begin
            unique case (ir[31:29])
                3'b000: begin
                    dec_cw = PC | cls(4'd1);
                    dec_k  = {{38{ir[25]}}, ir[25:0]};
                end
                3'b010: begin
                    dec_cw = PC | CD | cls(4'd2);
                    dec_k  = {{45{ir[23]}}, ir[23:5]};
                end
                3'b100: begin
                    if (step == '0) begin
                        dec_cw = RW | LK | cls(4'd3);
                        dec_ns = 1'b1;
                    end else begin
                        dec_cw = PC | cls(4'd3);
                        dec_k  = {{38{ir[25]}}, ir[25:0]};
                    end
                end
                3'b101: begin
                    dec_cw = PC | CZ | cls(4'd4) | rd_f;
                    dec_k  = {{45{ir[23]}}, ir[23:5]};
                end
                3'b110: dec_cw = PC | PR | cls(4'd5);
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            unique case (ir[25:23])
                3'b000: begin
                    dec_k = {{55{ir[20]}}, ir[20:12]};
                    if (step == '0) begin
                        dec_cw = AK | aop(4'b0010) | cls(4'd6) | rd_f | {9'b0, ir[28:27], 14'b0};
                        dec_ns = 1'b1;
                    end else begin
                        dec_cw = (ir[22] ? (MR | RW) : MW) | cls(4'd6) | rd_f | {9'b0, ir[28:27], 14'b0};
                    end
                end
                3'b010: begin
                    dec_cw = RW | AK | aop(ir[30] ? 4'b0110 : 4'b0010) | (ir[29] ? FL : '0)
                           | cls(4'd7) | rd_f;
                    dec_k  = {52'b0, ir[21:10]};
                end
                3'b100: begin
                    unique case (ir[30:29])
                        2'b00:   dec_cw = aop(4'b0000);
                        2'b01:   dec_cw = aop(4'b0001);
                        2'b10:   dec_cw = aop(4'b0011);
                        default: dec_cw = aop(4'b0000) | FL;
                    endcase
                    dec_cw = dec_cw | RW | AK | cls(4'd8) | rd_f;
                    dec_k  = {51'b0, ir[22:10]};
                end
                3'b101: begin
                    dec_cw = RW | AK | aop(4'b0111) | cls(4'd9) | rd_f;
                    dec_k  = {48'b0, ir[20:5]} << {ir[22:21], 4'b0};
                end
                3'b110: begin
                    dec_cw = RW | aop(ir[30] ? 4'b0110 : 4'b0010) | (ir[29] ? FL : '0)
                           | cls(4'd10) | rd_f;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign next_step   = STATE_BITS'(dec_ns);
    assign exec_live   = (state == EXEC) && !dec_illegal;
    assign controlWord = exec_live ? CW_BITS'(dec_cw) : NOP_CW;
    assign K           = exec_live ? K_BITS'(dec_k) : '0;
    assign instr_ready = (state == IDLE) || (exec_live && (next_step == '0) && !stall);
    assign cyc_next    = {1'b0, cyc} + (CNT_BITS + 1)'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ir      <= '0;
            step    <= '0;
            cyc     <= '0;
            flags   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == EXEC) && !stall && controlWord[FLAG_LOAD_BIT])
                flags <= status;
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instruction;
                        step  <= '0;
                        cyc   <= '0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (dec_illegal) begin
                        state   <= TRAP;
                        illegal <= 1'b1;
                    end else if (!stall) begin
                        if (next_step != '0) begin
                            if (cyc_next >= CNT_LIMIT) begin
                                state   <= TRAP;
                                illegal <= 1'b1;
                            end else begin
                                step <= next_step;
                                cyc  <= cyc_next[CNT_BITS-1:0];
                            end
                        end else begin
                            // Completion edge doubles as the accept edge for back-to-back issue.
                            done <= 1'b1;
                            step <= '0;
                            cyc  <= '0;
                            if (instr_valid) ir <= instruction;
                            else             state <= IDLE;
                        end
                    end
                end
                TRAP: begin
                    if (trap_clear) begin
                        state   <= IDLE;
                        illegal <= 1'b0;
                        step    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: table of single instructions plus
// hand-written stall, back-to-back, trap, reset and cycle-limit sequences.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  status;
    logic        stall;
    logic        trap_clear;
    logic [30:0] controlWord;
    logic [63:0] K;
    logic [4:0]  flags;
    logic [1:0]  step;
    logic        done;
    logic        illegal;

    logic [31:0] instruction2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic [30:0] controlWord2;
    logic [63:0] K2;
    logic [4:0]  flags2;
    logic [1:0]  step2;
    logic        done2;
    logic        illegal2;

    control_sequencer dut (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .status(status), .stall(stall), .trap_clear(trap_clear),
        .controlWord(controlWord), .K(K), .flags(flags), .step(step), .done(done),
        .illegal(illegal)
    );

    control_sequencer #(.MAX_CYCLES(1)) dut_lim (
        .clock(clock), .reset(reset), .instruction(instruction2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2), .status(5'b0), .stall(1'b0), .trap_clear(1'b0),
        .controlWord(controlWord2), .K(K2), .flags(flags2), .step(step2), .done(done2),
        .illegal(illegal2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        int          steps;
        logic [30:0] cw0;
        logic [63:0] k0;
        logic [30:0] cw1;
        logic [63:0] k1;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;
    int cur    = -1;
    logic [4:0] exp_flags;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s [%0d]: got %h, required %h", name, cur, act, exp);
    endtask

    task automatic offer(input logic [31:0] ins);
        @(negedge clock);
        instruction = ins;
        instr_valid = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1; instruction = '0; instr_valid = 1'b0; status = '0; stall = 1'b0;
        trap_clear = 1'b0; instruction2 = '0; instr_valid2 = 1'b0;

        vecs[0]  = '{32'h8B020020, 1, 31'h0A0802, 64'h0, 31'h0, 64'h0};
        vecs[1]  = '{32'hAB020020, 1, 31'h0A0803, 64'h0, 31'h0, 64'h0};
        vecs[2]  = '{32'hEB020020, 1, 31'h0A1803, 64'h0, 31'h0, 64'h0};
        vecs[3]  = '{32'hF8400020, 2, 31'h06C810, 64'h0, 31'h06C006, 64'h0};
        vecs[4]  = '{32'hF81F8020, 2, 31'h06C810, 64'hFFFFFFFFFFFFFFF8, 31'h06C008, 64'hFFFFFFFFFFFFFFF8};
        vecs[5]  = '{32'h14000004, 1, 31'h010020, 64'h4, 31'h0, 64'h0};
        vecs[6]  = '{32'h17FFFFFF, 1, 31'h010020, 64'hFFFFFFFFFFFFFFFF, 31'h0, 64'h0};
        vecs[7]  = '{32'h94000010, 2, 31'h030042, 64'h0, 31'h030020, 64'h10};
        vecs[8]  = '{32'hD2800540, 1, 31'h091C12, 64'h2A, 31'h0, 64'h0};
        vecs[9]  = '{32'hD2A00020, 1, 31'h091C12, 64'h10000, 31'h0, 64'h0};
        vecs[10] = '{32'h91000420, 1, 31'h070812, 64'h1, 31'h0, 64'h0};

        repeat (2) @(negedge clock);
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_cw", controlWord, 0);
        check("rst_k", K, 0);
        check("rst_flags", flags, 0);
        check("rst_step", step, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        @(negedge clock);
        reset = 1'b0;
        exp_flags = '0;

        for (int i = 0; i < NV; i++) begin
            cur = i;
            @(negedge clock);
            instruction = vecs[i].instr;
            instr_valid = 1'b1;
            status = 5'(i * 7 + 3);
            #1;
            check("idle_ready", instr_ready, 1);
            check("idle_cw", controlWord, 0);
            check("done_clear", done, 0);
            @(negedge clock);
            instr_valid = 1'b0;
            #1;
            check("cw_s0", controlWord, vecs[i].cw0);
            check("k_s0", K, vecs[i].k0);
            check("step_s0", step, 0);
            check("ready_s0", instr_ready, vecs[i].steps == 1);
            if (vecs[i].cw0[0]) exp_flags = status;
            if (vecs[i].steps == 2) begin
                @(negedge clock);
                #1;
                check("cw_s1", controlWord, vecs[i].cw1);
                check("k_s1", K, vecs[i].k1);
                check("step_s1", step, 1);
                check("ready_s1", instr_ready, 1);
                if (vecs[i].cw1[0]) exp_flags = status;
            end
            @(negedge clock);
            #1;
            check("done_pulse", done, 1);
            check("cw_after", controlWord, 0);
            check("step_after", step, 0);
            check("flags", flags, exp_flags);
        end

        // LDUR stalled three cycles at step 1
        cur = 100;
        offer(32'hF8400020);
        @(negedge clock); instr_valid = 1'b0;
        @(negedge clock);
        stall = 1'b1;
        #1;
        check("stall_ready", instr_ready, 0);
        check("stall_cw", controlWord, 31'h06C006);
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            #1;
            check("stall_step", step, 1);
            check("stall_cw_hold", controlWord, 31'h06C006);
            check("stall_no_done", done, 0);
        end
        stall = 1'b0;
        #1;
        check("stall_rel_ready", instr_ready, 1);
        @(negedge clock); #1;
        check("stall_done", done, 1);

        // Flags do not load while stalled
        cur = 101;
        offer(32'hAB020020);
        @(negedge clock);
        instr_valid = 1'b0; stall = 1'b1; status = 5'h0A;
        @(negedge clock); #1;
        check("flag_stall_hold", flags, exp_flags);
        check("flag_stall_nodone", done, 0);
        stall = 1'b0; status = 5'h15;
        @(negedge clock); #1;
        check("flag_load", flags, 5'h15);
        check("flag_done", done, 1);

        // ADD then B back to back
        cur = 102;
        offer(32'h8B020020);
        @(negedge clock);
        instruction = 32'h14000004;
        #1;
        check("b2b_ready", instr_ready, 1);
        check("b2b_cw_add", controlWord, 31'h0A0802);
        @(negedge clock);
        instr_valid = 1'b0;
        #1;
        check("b2b_done1", done, 1);
        check("b2b_cw_b", controlWord, 31'h010020);
        check("b2b_step", step, 0);
        @(negedge clock); #1;
        check("b2b_done2", done, 1);
        check("b2b_idle_cw", controlWord, 0);
        @(negedge clock); #1;
        check("b2b_done_low", done, 0);

        // Illegal opcode and trap clear
        cur = 103;
        offer(32'h00800000);
        @(negedge clock);
        instr_valid = 1'b0;
        #1;
        check("ill_cw", controlWord, 0);
        check("ill_ready_exec", instr_ready, 0);
        check("ill_not_yet", illegal, 0);
        @(negedge clock);
        instruction = 32'h8B020020; instr_valid = 1'b1;
        #1;
        check("trap_illegal", illegal, 1);
        check("trap_ready", instr_ready, 0);
        check("trap_cw", controlWord, 0);
        check("trap_done", done, 0);
        @(negedge clock);
        instr_valid = 1'b0; trap_clear = 1'b1;
        #1;
        check("trap_held", illegal, 1);
        @(negedge clock);
        trap_clear = 1'b0;
        #1;
        check("clear_illegal", illegal, 0);
        check("clear_ready", instr_ready, 1);

        // Reset during LDUR step 1
        cur = 104;
        offer(32'hF8400020);
        @(negedge clock); instr_valid = 1'b0;
        @(negedge clock); #1;
        check("prerst_step", step, 1);
        reset = 1'b1;
        #1;
        check("midrst_flags", flags, 0);
        check("midrst_step", step, 0);
        check("midrst_cw", controlWord, 0);
        check("midrst_ready", instr_ready, 1);
        check("midrst_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        check("postrst_done", done, 0);
        check("postrst_cw", controlWord, 0);

        // Cycle limit of one: single-step ADD completes, LDUR traps
        cur = 105;
        @(negedge clock);
        instruction2 = 32'h8B020020; instr_valid2 = 1'b1;
        @(negedge clock);
        instr_valid2 = 1'b0;
        @(negedge clock); #1;
        check("lim_add_done", done2, 1);
        check("lim_add_ok", illegal2, 0);
        @(negedge clock);
        instruction2 = 32'hF8400020; instr_valid2 = 1'b1;
        @(negedge clock);
        instr_valid2 = 1'b0;
        #1;
        check("lim_ldur_cw", controlWord2, 31'h06C810);
        @(negedge clock); #1;
        check("lim_trap", illegal2, 1);
        check("lim_no_done", done2, 0);
        check("lim_ready", instr_ready2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout [%0d]: got running, required finished", cur);
        $fatal(1);
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter CW_BITS, default 31, width of controlWord.
REQ-002 Parameter K_BITS, default 64, width of constant output K.
REQ-003 Parameter STATE_BITS, default 2, width of the step counter; minimum 2; decoder next-state values zero-extended to STATE_BITS.
REQ-004 Parameter MAX_CYCLES, default 8, limit on non-stalled cycles per instruction before trap.
REQ-005 Parameter NOP_CW, default all-zero, controlWord driven when no instruction executes.
REQ-006 Parameter FLAG_LOAD_BIT, default 0, controlWord bit index that enables flag capture.
REQ-007 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-008 Port reset  input  1  asynchronous, active-high reset.
REQ-009 Port instruction  input  32  instruction word offered by fetch.
REQ-010 Port instr_valid  input  1  instruction holds a valid word.
REQ-011 Port instr_ready  output  1  sequencer accepts the instruction this cycle.
REQ-012 Port status  input  5  ALU flags V, C, N, Z plus spare bit.
REQ-013 Port stall  input  1  memory not ready; freezes sequencing.
REQ-014 Port trap_clear  input  1  leaves TRAP state.
REQ-015 Port controlWord  output  CW_BITS  datapath control word.
REQ-016 Port K  output  K_BITS  immediate/constant for the datapath.
REQ-017 Port flags  output  5  registered status.
REQ-018 Port step  output  STATE_BITS  current step within the instruction.
REQ-019 Port done  output  1  one-cycle pulse when an instruction completes.
REQ-020 Port illegal  output  1  high while in TRAP.

Function
REQ-021 FSM states IDLE, EXEC, TRAP; register IR (32), step, cycle counter, flags.
REQ-022 Transfer occurs when instr_valid and instr_ready are both high on a rising edge; IR <= instruction, step <= 0, state <= EXEC.
REQ-023 instr_ready = (IDLE) or (EXEC and decoder next-state = 0 and stall = 0); low in TRAP.
REQ-024 Decode from IR opcode = IR[31:21]: opcode[5]=1 selects branch class by opcode[10:8] (000 B, 010 B.cond, 100 BL, 101 CBZ/CBNZ, 110 BR); opcode[5]=0 selects by opcode[4:2] (000 D-transfer, 010 I-arith, 100 I-logic, 101 IW, 110 R-ALU).
REQ-025 Any other selector value is illegal; decoders are combinational in (IR, step) and return control word, K, next-state.
REQ-026 In EXEC: controlWord/K are the selected decoder outputs, combinational from IR and step (zero added latency).
REQ-027 In IDLE and TRAP: controlWord = NOP_CW, K = 0.
REQ-028 EXEC, stall=1: step, IR, cycle counter hold; controlWord unchanged.
REQ-029 EXEC, stall=0, next-state != 0: step <= next-state, cycle counter +1.
REQ-030 EXEC, stall=0, next-state = 0: done=1 next cycle; back to IDLE, or EXEC with new IR and step 0 if a transfer occurs the same edge (back-to-back).
REQ-031 Illegal opcode in EXEC at step 0: next edge state <= TRAP, no datapath side effects (controlWord = NOP_CW during that cycle).
REQ-032 Cycle counter reaching MAX_CYCLES without completion: state <= TRAP.
REQ-033 TRAP: trap_clear=1 -> IDLE next edge; IR retained; illegal=1 until then.
REQ-034 flags <= status on any edge where state is EXEC, stall=0 and controlWord[FLAG_LOAD_BIT]=1; otherwise hold.
REQ-035 done registered; never high two consecutive cycles for one instruction.

Reset
REQ-036 reset=1 asynchronously forces IDLE, IR=0, step=0, cycle counter=0, flags=0, done=0, illegal=0; instr_ready=1 and controlWord=NOP_CW while reset is high and after release.
REQ-037 Reset mid-instruction abandons it with no done pulse.

Verification
REQ-038 Reset, offer ADD X0,X1,X2 (0x8B020020) with valid -> accepted in one cycle, step 0, R-ALU control word, done pulse at completion, back to IDLE.
REQ-039 LDUR X0,[X1] (0xF8400020), decoder sequence 0->1->0, stall=1 for 3 cycles at step 1 -> step stays 1, controlWord constant, done 4 cycles after stall release begins counting (1 cycle after release).
REQ-040 ADD then B (0x14000004) offered continuously -> B accepted on ADD's final edge, no IDLE cycle, two done pulses.
REQ-041 Instruction 0x00800000 -> illegal=1 next cycle, controlWord=NOP_CW, instr_ready=0; trap_clear -> IDLE.
REQ-042 Assert reset during LDUR step 1 -> outputs at reset values immediately, no done, flags=0.
